// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU: opcodes, phase encodings and
// control-word bit positions used by the cycle decoder.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] PH_T0 = 2'b00;
  localparam logic [1:0] PH_T1 = 2'b01;
  localparam logic [1:0] PH_T2 = 2'b10;
  localparam logic [1:0] PH_T3 = 2'b11;

  localparam int CW_MAR_PC   = 0;
  localparam int CW_MAR_IR   = 1;
  localparam int CW_MEM_RD   = 2;
  localparam int CW_MEM_WR   = 3;
  localparam int CW_IR_LOAD  = 4;
  localparam int CW_PC_INC   = 5;
  localparam int CW_PC_LOAD  = 6;
  localparam int CW_ACC_LOAD = 7;
  localparam int CW_ALU_EN   = 8;
  localparam int CW_ALU_SUB  = 9;
  localparam int CW_W        = 10;

endpackage

// File: rtl/cycle_op_decode.sv
// Combinational (phase, opcode) -> control word. The caller supplies the
// latched opcode during T3 so execute strobes never follow a changing IR.
module cycle_op_decode
  import cpu_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [1:0]      phase,
  input  logic [OP_W-1:0] op,
  output logic [CW_W-1:0] cw
);

  always_comb begin
    cw = '0;
    case (phase)
      PH_T0: begin
        cw[CW_MAR_PC] = 1'b1;
        cw[CW_MEM_RD] = 1'b1;
      end
      PH_T1: begin
        cw[CW_IR_LOAD] = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      PH_T2: begin
        case (op)
          OP_W'(OP_LDA), OP_W'(OP_STA), OP_W'(OP_ADD), OP_W'(OP_SUB):
            cw[CW_MAR_IR] = 1'b1;
          OP_W'(OP_JMP):
            cw[CW_PC_LOAD] = 1'b1;
          default: ;
        endcase
      end
      default: begin
        case (op)
          OP_W'(OP_LDA): begin
            cw[CW_MEM_RD]   = 1'b1;
            cw[CW_ACC_LOAD] = 1'b1;
          end
          OP_W'(OP_ADD): begin
            cw[CW_MEM_RD]   = 1'b1;
            cw[CW_ACC_LOAD] = 1'b1;
            cw[CW_ALU_EN]   = 1'b1;
          end
          OP_W'(OP_SUB): begin
            cw[CW_MEM_RD]   = 1'b1;
            cw[CW_ACC_LOAD] = 1'b1;
            cw[CW_ALU_EN]   = 1'b1;
            cw[CW_ALU_SUB]  = 1'b1;
          end
          OP_W'(OP_STA):
            cw[CW_MEM_WR] = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/cycle_decoder.sv
// Instruction-cycle control decoder with phase-sequence checking.
// Optional undefined-opcode trap: define CYCLE_DECODER_ILLEGAL_TRAP_EN.
module cycle_decoder
  import cpu_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [1:0]      state,
  input  logic [OP_W-1:0] opcode,
  output logic [3:0]      tphase,
  output logic            mar_from_pc,
  output logic            mar_from_ir,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            acc_load,
  output logic            alu_en,
  output logic            alu_sub,
  output logic            halted,
  output logic            seq_err,
  output logic            illegal
);

  logic [1:0]      exp_reg;
  logic [OP_W-1:0] op_q_reg;
  logic            halted_reg;
  logic            seq_err_reg;
  logic [3:0]      tphase_reg;
  logic [3:0]      tphase_next;
  logic [CW_W-1:0] cw_reg;
  logic [CW_W-1:0] cw_next;
  logic [OP_W-1:0] dec_op;
  logic            hlt_now;
  logic            trap_now;
  logic            halted_next;
  logic            seq_err_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tphase
      assign tphase_next[gi] = (state == 2'(gi));
    end
  endgenerate

  // Execute phase decodes the opcode captured at T2, not the live IR.
  assign dec_op = (state == PH_T3) ? op_q_reg : opcode;

  cycle_op_decode #(.OP_W(OP_W)) u_dec (
    .phase (state),
    .op    (dec_op),
    .cw    (cw_next)
  );

  assign hlt_now      = (state == PH_T2) && (opcode == OP_W'(OP_HLT));
  assign halted_next  = halted_reg | hlt_now | trap_now;
  assign seq_err_next = seq_err_reg | (state != exp_reg);

`ifdef CYCLE_DECODER_ILLEGAL_TRAP_EN
  logic illegal_reg;

  assign trap_now = (state == PH_T2) &&
                    !(opcode inside {OP_W'(OP_NOP), OP_W'(OP_LDA), OP_W'(OP_STA),
                                     OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_JMP),
                                     OP_W'(OP_HLT)});

  always_ff @(posedge clk) begin
    if (clear) illegal_reg <= 1'b0;
    else       illegal_reg <= illegal_reg | trap_now;
  end

  assign illegal = illegal_reg;
`else
  assign trap_now = 1'b0;
  assign illegal  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      exp_reg     <= PH_T0;
      op_q_reg    <= '0;
      halted_reg  <= 1'b0;
      seq_err_reg <= 1'b0;
      tphase_reg  <= '0;
      cw_reg      <= '0;
    end else begin
      exp_reg     <= exp_reg + 2'd1;
      halted_reg  <= halted_next;
      seq_err_reg <= seq_err_next;
      if (state == PH_T2) op_q_reg <= opcode;
      // The flag and the silenced outputs appear in the same cycle.
      if (halted_next || seq_err_next) begin
        tphase_reg <= '0;
        cw_reg     <= '0;
      end else begin
        tphase_reg <= tphase_next;
        cw_reg     <= cw_next;
      end
    end
  end

  assign tphase      = tphase_reg;
  assign mar_from_pc = cw_reg[CW_MAR_PC];
  assign mar_from_ir = cw_reg[CW_MAR_IR];
  assign mem_rd      = cw_reg[CW_MEM_RD];
  assign mem_wr      = cw_reg[CW_MEM_WR];
  assign ir_load     = cw_reg[CW_IR_LOAD];
  assign pc_inc      = cw_reg[CW_PC_INC];
  assign pc_load     = cw_reg[CW_PC_LOAD];
  assign acc_load    = cw_reg[CW_ACC_LOAD];
  assign alu_en      = cw_reg[CW_ALU_EN];
  assign alu_sub     = cw_reg[CW_ALU_SUB];
  assign halted      = halted_reg;
  assign seq_err     = seq_err_reg;

endmodule

// File: tb/tb_cycle_decoder.sv
// Directed self-checking bench for cycle_decoder; the undefined-opcode
// expectations follow CYCLE_DECODER_ILLEGAL_TRAP_EN when it is defined.
module tb_cycle_decoder;

  logic       clk;
  logic       clear;
  logic [1:0] state;
  logic [3:0] opcode;
  logic [3:0] tphase;
  logic mar_from_pc, mar_from_ir, mem_rd, mem_wr, ir_load;
  logic pc_inc, pc_load, acc_load, alu_en, alu_sub;
  logic halted, seq_err, illegal;

  int n_chk  = 0;
  int n_fail = 0;

  // Bench-side strobe word: {alu_sub, alu_en, acc_load, pc_load, pc_inc,
  //                          ir_load, mem_wr, mem_rd, mar_from_ir, mar_from_pc}
  localparam logic [9:0] S_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] S_T0    = 10'b00_0000_0101;
  localparam logic [9:0] S_T1    = 10'b00_0011_0000;
  localparam logic [9:0] S_T2MEM = 10'b00_0000_0010;
  localparam logic [9:0] S_T2JMP = 10'b00_0100_0000;
  localparam logic [9:0] S_LDA   = 10'b00_1000_0100;
  localparam logic [9:0] S_ADD   = 10'b01_1000_0100;
  localparam logic [9:0] S_SUB   = 10'b11_1000_0100;
  localparam logic [9:0] S_STA   = 10'b00_0000_1000;

  cycle_decoder #(.OP_W(4)) dut (
    .clk         (clk),
    .clear       (clear),
    .state       (state),
    .opcode      (opcode),
    .tphase      (tphase),
    .mar_from_pc (mar_from_pc),
    .mar_from_ir (mar_from_ir),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .acc_load    (acc_load),
    .alu_en      (alu_en),
    .alu_sub     (alu_sub),
    .halted      (halted),
    .seq_err     (seq_err),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // flags = {illegal, seq_err, halted}
  task automatic chk_all(input string tag, input logic [3:0] e_tph,
                         input logic [9:0] e_cw, input logic [2:0] e_flags);
    logic [9:0] cw_obs;
    cw_obs = {alu_sub, alu_en, acc_load, pc_load, pc_inc,
              ir_load, mem_wr, mem_rd, mar_from_ir, mar_from_pc};
    chk({tag, ".tphase"}, 16'(tphase), 16'(e_tph));
    chk({tag, ".strobes"}, 16'(cw_obs), 16'(e_cw));
    chk({tag, ".flags"}, 16'({illegal, seq_err, halted}), 16'(e_flags));
    $display("step %-14s tphase=%b strobes=%b flags=%b", tag, tphase, cw_obs,
             {illegal, seq_err, halted});
  endtask

  task automatic do_clear(input string tag, input logic [1:0] st);
    clear = 1'b1;
    state = st;
    tick();
    chk_all(tag, 4'b0000, S_NONE, 3'b000);
    clear = 1'b0;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] op_late,
                           input logic [9:0] cw_t2, input logic [9:0] cw_t3);
    state = 2'b00; opcode = op; tick();
    chk_all({tag, ".t0"}, 4'b0001, S_T0, 3'b000);
    state = 2'b01; tick();
    chk_all({tag, ".t1"}, 4'b0010, S_T1, 3'b000);
    state = 2'b10; tick();
    chk_all({tag, ".t2"}, 4'b0100, cw_t2, 3'b000);
    state = 2'b11; opcode = op_late; tick();
    chk_all({tag, ".t3"}, 4'b1000, cw_t3, 3'b000);
  endtask

  initial begin
    clear  = 1'b1;
    state  = 2'b00;
    opcode = 4'h0;

    do_clear("reset", 2'b00);

    run_instr("lda", 4'h1, 4'h1, S_T2MEM, S_LDA);
    run_instr("sub", 4'h4, 4'h4, S_T2MEM, S_SUB);
    run_instr("sta", 4'h2, 4'h2, S_T2MEM, S_STA);
    run_instr("add_late5", 4'h3, 4'h5, S_T2MEM, S_ADD);
    run_instr("jmp", 4'h5, 4'h5, S_T2JMP, S_NONE);
    run_instr("nop", 4'h0, 4'h0, S_NONE, S_NONE);

`ifdef CYCLE_DECODER_ILLEGAL_TRAP_EN
    state = 2'b00; opcode = 4'h9; tick();
    chk_all("ill.t0", 4'b0001, S_T0, 3'b000);
    state = 2'b01; tick();
    chk_all("ill.t1", 4'b0010, S_T1, 3'b000);
    state = 2'b10; tick();
    chk_all("ill.t2", 4'b0000, S_NONE, 3'b101);
    state = 2'b11; tick();
    chk_all("ill.t3", 4'b0000, S_NONE, 3'b101);
    state = 2'b00; tick();
    chk_all("ill.after", 4'b0000, S_NONE, 3'b101);
`else
    run_instr("undef9", 4'h9, 4'h9, S_NONE, S_NONE);
    run_instr("after9", 4'h1, 4'h1, S_T2MEM, S_LDA);
`endif
    do_clear("clr1", 2'b01);

    // Halt: outputs stay silent while the phase check keeps running.
    state = 2'b00; opcode = 4'hF; tick();
    chk_all("hlt.t0", 4'b0001, S_T0, 3'b000);
    state = 2'b01; tick();
    chk_all("hlt.t1", 4'b0010, S_T1, 3'b000);
    state = 2'b10; tick();
    chk_all("hlt.t2", 4'b0000, S_NONE, 3'b001);
    for (int i = 0; i < 8; i++) begin
      state = 2'(i + 3);
      tick();
      chk_all($sformatf("hlt.idle%0d", i), 4'b0000, S_NONE, 3'b001);
    end
    state = 2'b00; tick();
    chk_all("hlt.seqerr", 4'b0000, S_NONE, 3'b011);
    do_clear("clr2", 2'b00);

    // Sequence error: exp is 01 when 10 is presented.
    state = 2'b00; opcode = 4'h1; tick();
    chk_all("seq.t0", 4'b0001, S_T0, 3'b000);
    state = 2'b10; tick();
    chk_all("seq.bad", 4'b0000, S_NONE, 3'b010);
    state = 2'b11; tick();
    chk_all("seq.hold1", 4'b0000, S_NONE, 3'b010);
    state = 2'b00; tick();
    chk_all("seq.hold2", 4'b0000, S_NONE, 3'b010);
    do_clear("clr_vs_err", 2'b10);
    run_instr("recover", 4'h1, 4'h1, S_T2MEM, S_LDA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
